mult2_accum: RTL and testbench

MULT2_ACCUM -- requirements
Module: mult2_accum

---
 rtl/mult2_pkg.sv | 16 +
 rtl/mult2_accum.sv | 105 ++++++++++
 tb/tb_mult2_accum.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mult2_pkg.sv
// Shared types and default sizing for the 2-bit multiplier accumulator.
package mult2_pkg;

  // Group-length width and accumulator width. The accumulator is 4 bits wider
  // than the length, so 2^LEN_W products of at most 15 always fit.
  localparam int LEN_W_DEF = 4;
  localparam int ACC_W_DEF = LEN_W_DEF + 4;

  // Accumulator FSM: waiting for a first product, summing a group, holding a result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mult2_accum.sv
// Sums groups of 4-bit products from the 2-bit multiplier stage. A group is
// `len` products long (0 meaning 2^LEN_W). len is latched on the first product.
// The finished sum is offered on a valid/ready port. While that sum waits,
// upstream is stalled. clear aborts the current group and drops a pending sum.
module mult2_accum
  import mult2_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int ACC_W = ACC_W_DEF   // must be LEN_W + 4 so the sum cannot overflow
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [LEN_W-1:0] len,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_data,
  output logic             acc_valid,
  input  logic             acc_ready
);

  // One extra bit so the counter and the target can represent 2^LEN_W.
  localparam int CNT_W = LEN_W + 1;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] tgt, tgt_nxt;
  logic [CNT_W-1:0] len_tgt;
  logic [CNT_W-1:0] cnt_inc;
  logic [ACC_W-1:0] prod_ext;
  logic             accept;
  logic             taken;

  assign prod_ready = (state != DONE);
  assign acc_valid  = (state == DONE);
  assign acc_data   = acc;

  assign accept   = prod_valid & prod_ready;
  assign taken    = acc_valid & acc_ready;
  assign prod_ext = {{(ACC_W-4){1'b0}}, prod};
  assign cnt_inc  = cnt + CNT_W'(1);
  // A zero length selects the largest group, 2^LEN_W.
  assign len_tgt  = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};

  // Next-state and datapath update. clear overrides every other event.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    tgt_nxt   = tgt;
    if (clear) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_nxt   = prod_ext;
            cnt_nxt   = CNT_W'(1);
            tgt_nxt   = len_tgt;
            state_nxt = (len_tgt == CNT_W'(1)) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_nxt = acc + prod_ext;
            cnt_nxt = cnt_inc;
            if (cnt_inc == tgt) state_nxt = DONE;
          end
        end
        DONE: begin
          if (taken) begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State registers. Reset discards any partial or pending sum.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      tgt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      tgt   <= tgt_nxt;
    end
  end

endmodule

// File: tb/tb_mult2_accum.sv
// Self-checking bench for mult2_accum: table of whole groups, hand sequences
// for stall/clear/reset/len-change, then random traffic against a queue model.
module tb_mult2_accum;

  logic       clock;
  logic       reset_n;
  logic [3:0] prod;
  logic       prod_valid;
  logic       prod_ready;
  logic [3:0] len;
  logic       clear;
  logic [7:0] acc_data;
  logic       acc_valid;
  logic       acc_ready;

  int n_chk  = 0;
  int n_pass = 0;

  mult2_accum #(.LEN_W(4), .ACC_W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .len        (len),
    .clear      (clear),
    .acc_data   (acc_data),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [3:0]       len;
    int               n;
    logic [15:0][3:0] p;
    logic [7:0]       exp;
  } vec_t;

  vec_t vecs[5];

  // Drives one full group back to back with acc_ready high and checks the result.
  task automatic run_group(input vec_t v, input int idx);
    for (int i = 0; i < v.n; i++) begin
      @(negedge clock);
      chk($sformatf("v%0d ready[%0d]", idx, i), prod_ready, 1);
      chk($sformatf("v%0d novalid[%0d]", idx, i), acc_valid, 0);
      prod_valid = 1'b1;
      prod       = v.p[i];
      len        = v.len;
    end
    @(negedge clock);
    prod_valid = 1'b0;
    chk($sformatf("v%0d valid", idx), acc_valid, 1);
    chk($sformatf("v%0d data", idx), acc_data, v.exp);
    chk($sformatf("v%0d stall", idx), prod_ready, 0);
    @(negedge clock);
    chk($sformatf("v%0d valid_drop", idx), acc_valid, 0);
    chk($sformatf("v%0d idle_ready", idx), prod_ready, 1);
  endtask

  // Random-phase reference model: products of the open group, and a pending sum.
  logic [3:0] grp[$];
  int         grp_tgt;
  bit         pend;
  int         pend_sum;

  initial begin
    reset_n = 1'b0; prod = '0; prod_valid = 1'b0; len = '0; clear = 1'b0; acc_ready = 1'b1;

    // Group table: expected sums worked out by hand.
    vecs[0].len = 4'd3; vecs[0].n = 3;  vecs[0].p = '0; vecs[0].exp = 8'd19;
    vecs[0].p[0] = 4'd9; vecs[0].p[1] = 4'd6; vecs[0].p[2] = 4'd4;
    vecs[1].len = 4'd0; vecs[1].n = 16; vecs[1].p = '0; vecs[1].exp = 8'd240;
    for (int i = 0; i < 16; i++) vecs[1].p[i] = 4'd15;
    vecs[2].len = 4'd2; vecs[2].n = 2;  vecs[2].p = '0; vecs[2].exp = 8'd3;
    vecs[2].p[0] = 4'd1; vecs[2].p[1] = 4'd2;
    vecs[3].len = 4'd5; vecs[3].n = 5;  vecs[3].p = '0; vecs[3].exp = 8'd31;
    vecs[3].p[0] = 4'd15; vecs[3].p[1] = 4'd0; vecs[3].p[2] = 4'd7;
    vecs[3].p[3] = 4'd8; vecs[3].p[4] = 4'd1;
    vecs[4].len = 4'd1; vecs[4].n = 1;  vecs[4].p = '0; vecs[4].exp = 8'd0;

    // Reset state.
    #2;
    chk("rst data", acc_data, 0);
    chk("rst valid", acc_valid, 0);
    chk("rst ready", prod_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;

    for (int k = 0; k < 5; k++) run_group(vecs[k], k);

    // Held result: acc_ready low for 5 cycles, a product waiting upstream meanwhile.
    @(negedge clock);
    len = 4'd1; prod = 4'd4; prod_valid = 1'b1; acc_ready = 1'b0;
    @(negedge clock);
    prod = 4'd7;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold valid[%0d]", i), acc_valid, 1);
      chk($sformatf("hold data[%0d]", i), acc_data, 4);
      chk($sformatf("hold ready[%0d]", i), prod_ready, 0);
      @(negedge clock);
    end
    acc_ready = 1'b1;
    @(negedge clock);
    prod_valid = 1'b0;
    chk("hold taken", acc_valid, 0);
    chk("hold no_accept", acc_data, 0);

    // clear with a simultaneous product drops it; next group is unaffected.
    @(negedge clock);
    len = 4'd4; prod = 4'd3; prod_valid = 1'b1;
    @(negedge clock);
    prod = 4'd2;
    @(negedge clock);
    prod = 4'd9; clear = 1'b1;
    @(negedge clock);
    clear = 1'b0; prod_valid = 1'b0;
    chk("clr valid", acc_valid, 0);
    chk("clr data", acc_data, 0);
    chk("clr ready", prod_ready, 1);
    len = 4'd1; prod = 4'd1; prod_valid = 1'b1;
    @(negedge clock);
    prod_valid = 1'b0;
    chk("clr next valid", acc_valid, 1);
    chk("clr next data", acc_data, 1);
    @(negedge clock);

    // Asynchronous reset in the middle of a group.
    len = 4'd4; prod = 4'd5; prod_valid = 1'b1;
    @(negedge clock);
    prod = 4'd6;
    @(negedge clock);
    prod_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst data", acc_data, 0);
    chk("arst valid", acc_valid, 0);
    chk("arst ready", prod_ready, 1);
    @(negedge clock);
    chk("arst hold valid", acc_valid, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("arst after valid", acc_valid, 0);

    // len changes after the first product must not change the group length.
    len = 4'd2; prod = 4'd3; prod_valid = 1'b1;
    @(negedge clock);
    len = 4'd7; prod = 4'd4;
    @(negedge clock);
    prod_valid = 1'b0;
    chk("len latch valid", acc_valid, 1);
    chk("len latch data", acc_data, 7);
    @(negedge clock);
    chk("len latch done", acc_valid, 0);

    // Random traffic against the queue model.
    grp.delete(); pend = 0; pend_sum = 0; grp_tgt = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      chk("rnd ready", prod_ready, pend ? 0 : 1);
      chk("rnd valid", acc_valid, pend ? 1 : 0);
      if (pend) chk("rnd data", acc_data, pend_sum);
      prod_valid = ($urandom_range(0, 3) != 0);
      prod       = 4'($urandom_range(0, 15));
      len        = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
      acc_ready  = ($urandom_range(0, 2) != 0);
      clear      = ($urandom_range(0, 29) == 0);
      if (clear) begin
        grp.delete(); pend = 0;
      end else if (pend) begin
        if (acc_ready) pend = 0;
      end else if (prod_valid) begin
        if (grp.size() == 0) grp_tgt = (len == 0) ? 16 : int'(len);
        grp.push_back(prod);
        if (grp.size() == grp_tgt) begin
          pend_sum = 0;
          foreach (grp[j]) pend_sum += int'(grp[j]);
          pend = 1;
          grp.delete();
        end
      end
    end
    @(negedge clock);
    clear = 1'b0; prod_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
